axi_lite_regtest_master: RTL and testbench

- Synthesizable AXI4-Lite master for hardware self-test of a register-mapped slave such as the tps2358 peripheral.
- Per run it walks C_NUM_REGS word addresses from a base. At each address it writes a generated pattern, reads it back and checks both the read data and the response code.
- It reports pass/fail, an error count and the first failing location.
- It sits beside the MicroBlaze/PS interconnect as a second master, for board bring-up and production test.

---
 rtl/axi_lite_regtest_pkg.sv | 36 +++
 rtl/axi_lite_regtest_patgen.sv | 81 ++++++++
 rtl/axi_lite_regtest_master.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi_lite_regtest_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_regtest_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regtest_pkg
// Purpose  : Shared constants and types for the AXI4-Lite register self-test
//            master: response codes, pattern modes, FSM states, LFSR taps.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_regtest_pkg;

    // AXI response codes; anything other than OKAY counts as an error
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    // Pattern mode encodings as seen on the mode input
    localparam logic [1:0] MODE_INCR  = 2'd0;
    localparam logic [1:0] MODE_WALK  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    // Run sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_BR   = 3'd2,
        ST_AR   = 3'd3,
        ST_RD   = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Right-shifting Galois LFSR feedback masks (maximal-length polynomials)
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

endpackage
`default_nettype wire

// File: rtl/axi_lite_regtest_patgen.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regtest_patgen
// Purpose  : Expected-word generator. Mode and seed are captured on load; the
//            output is a function of the captured state and the register index
//            so the same word serves both the write and the read compare.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regtest_patgen
    import axi_lite_regtest_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int IDX_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_adv,
    input  logic [1:0]              i_mode,
    input  logic [C_DATA_WIDTH-1:0] i_seed,
    input  logic [IDX_W-1:0]        i_idx,
    output logic [C_DATA_WIDTH-1:0] o_pattern
);

    localparam int SH_W = $clog2(C_DATA_WIDTH);
    localparam logic [C_DATA_WIDTH-1:0] c_one = {{(C_DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              r_mode;
    logic [C_DATA_WIDTH-1:0] r_seed;
    logic [C_DATA_WIDTH-1:0] r_lfsr;
    logic [C_DATA_WIDTH-1:0] w_taps;
    logic [C_DATA_WIDTH-1:0] w_lfsr_next;
    logic [C_DATA_WIDTH-1:0] w_idx_ext;
    logic [SH_W-1:0]         w_shamt;

    generate
        if (C_DATA_WIDTH == 64) begin : g_taps64
            assign w_taps = LFSR_TAPS_64;
        end else begin : g_taps32
            assign w_taps = LFSR_TAPS_32;
        end
    endgenerate

    // Index helpers and one LFSR step
    always_comb begin
        w_idx_ext   = {{(C_DATA_WIDTH-IDX_W){1'b0}}, i_idx};
        // data width is a power of two, so the low index bits are idx mod W
        w_shamt     = i_idx[SH_W-1:0];
        w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? w_taps : '0);
    end

    // Capture seed/mode at run start; step the LFSR only between registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_INCR;
            r_seed <= '0;
            r_lfsr <= '0;
        end else if (i_load) begin
            r_mode <= i_mode;
            r_seed <= i_seed;
            // an all-zero state would lock the LFSR, so zero seeds become all-ones
            r_lfsr <= (i_seed == '0) ? '1 : i_seed;
        end else if (i_adv) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Select the expected word for the current index
    always_comb begin
        o_pattern = r_seed;
        case (r_mode)
            MODE_INCR:  o_pattern = r_seed + w_idx_ext;
            MODE_WALK:  o_pattern = c_one << w_shamt;
            MODE_LFSR:  o_pattern = r_lfsr;
            MODE_CHECK: o_pattern = i_idx[0] ? ~r_seed : r_seed;
            default:    o_pattern = r_seed;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_regtest_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regtest_master
// Purpose  : AXI4-Lite self-test master. Walks C_NUM_REGS addresses, writes a
//            generated word, reads it back and checks data and responses.
//            Reports pass/fail, a saturating error count and the first failure.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regtest_master
    import axi_lite_regtest_pkg::*;
#(
    parameter int                      C_ADDR_WIDTH  = 32,
    parameter int                      C_DATA_WIDTH  = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR   = '0,
    parameter int                      C_NUM_REGS    = 4,
    parameter int                      C_ADDR_STRIDE = 4,
    parameter int                      C_TIMEOUT     = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [C_DATA_WIDTH-1:0]   seed,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [7:0]                err_count,
    output logic [C_ADDR_WIDTH-1:0]   first_err_addr,
    output logic [C_DATA_WIDTH-1:0]   first_err_data,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int IDX_W  = 8;
    localparam int TCNT_W = $clog2(C_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]        c_last_idx = IDX_W'(C_NUM_REGS - 1);
    localparam logic [IDX_W-1:0]        c_idx_one  = IDX_W'(1);
    localparam logic [TCNT_W-1:0]       c_tmo_last = TCNT_W'(C_TIMEOUT - 1);
    localparam logic [TCNT_W-1:0]       c_tcnt_one = TCNT_W'(1);
    localparam logic [C_ADDR_WIDTH-1:0] c_stride   = C_ADDR_WIDTH'(C_ADDR_STRIDE);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [C_ADDR_WIDTH-1:0] r_addr;
    logic [TCNT_W-1:0]       r_tcnt;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_done;
    logic                    r_timeout;
    logic [7:0]              r_err_count;
    logic [C_ADDR_WIDTH-1:0] r_first_addr;
    logic [C_DATA_WIDTH-1:0] r_first_data;

    logic [C_DATA_WIDTH-1:0] w_pattern;
    logic [C_DATA_WIDTH-1:0] w_err_data;
    logic [7:0]              w_err_inc;
    logic                    w_aw_ok;
    logic                    w_w_ok;
    logic                    w_last;
    logic                    w_start_ok;
    logic                    w_adv;
    logic                    w_waiting;
    logic                    w_progress;
    logic                    w_err_hit;
    logic                    w_abort;

    axi_lite_regtest_patgen #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .IDX_W        (IDX_W)
    ) u_patgen (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_load    (w_start_ok),
        .i_adv     (w_adv),
        .i_mode    (mode),
        .i_seed    (seed),
        .i_idx     (r_idx),
        .o_pattern (w_pattern)
    );

    // Per-state progress, error detection and timeout decision
    always_comb begin
        w_aw_ok    = ~r_awvalid | M_AXI_AWREADY;
        w_w_ok     = ~r_wvalid  | M_AXI_WREADY;
        w_last     = (r_idx == c_last_idx);
        w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
        w_adv      = (r_state == ST_NEXT) & ~w_last;
        w_err_inc  = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;
        w_waiting  = 1'b0;
        w_progress = 1'b1;
        w_err_hit  = 1'b0;
        w_err_data = M_AXI_RDATA;
        case (r_state)
            ST_WR: begin
                w_waiting  = 1'b1;
                w_progress = w_aw_ok & w_w_ok;
            end
            ST_BR: begin
                w_waiting  = 1'b1;
                w_progress = M_AXI_BVALID;
                w_err_hit  = M_AXI_BVALID & (M_AXI_BRESP != RESP_OKAY);
                // a rejected write reports the word that was written
                w_err_data = w_pattern;
            end
            ST_AR: begin
                w_waiting  = 1'b1;
                w_progress = M_AXI_ARREADY;
            end
            ST_RD: begin
                w_waiting  = 1'b1;
                w_progress = M_AXI_RVALID;
                // bad response and bad data on the same beat still count once
                w_err_hit  = M_AXI_RVALID &
                             ((M_AXI_RRESP != RESP_OKAY) | (M_AXI_RDATA != w_pattern));
            end
            default: ;
        endcase
        w_abort = w_waiting & ~w_progress & (r_tcnt == c_tmo_last);
    end

    // Run sequencer with registered channel controls and result capture
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_addr       <= '0;
            r_tcnt       <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
        end else if (w_abort) begin
            // stalled handshake: abandon the transfer; the bus needs a reset
            r_state     <= ST_DONE;
            r_tcnt      <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_timeout   <= 1'b1;
            r_done      <= 1'b1;
            r_err_count <= w_err_inc;
        end else begin
            r_tcnt <= r_tcnt + c_tcnt_one;
            if (w_err_hit) begin
                r_err_count <= w_err_inc;
                if (r_err_count == 8'd0) begin
                    r_first_addr <= r_addr;
                    r_first_data <= w_err_data;
                end
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_tcnt <= '0;
                    if (start) begin
                        r_state      <= ST_WR;
                        r_idx        <= '0;
                        r_addr       <= C_BASE_ADDR;
                        r_awvalid    <= 1'b1;
                        r_wvalid     <= 1'b1;
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_err_count  <= '0;
                        r_first_addr <= '0;
                        r_first_data <= '0;
                    end
                end
                ST_WR: begin
                    if (M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_state  <= ST_BR;
                        r_bready <= 1'b1;
                        r_tcnt   <= '0;
                    end
                end
                ST_BR: begin
                    if (M_AXI_BVALID) begin
                        r_state   <= ST_AR;
                        r_bready  <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_tcnt    <= '0;
                    end
                end
                ST_AR: begin
                    if (M_AXI_ARREADY) begin
                        r_state   <= ST_RD;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_tcnt    <= '0;
                    end
                end
                ST_RD: begin
                    if (M_AXI_RVALID) begin
                        r_state  <= ST_NEXT;
                        r_rready <= 1'b0;
                        r_tcnt   <= '0;
                    end
                end
                ST_NEXT: begin
                    r_tcnt <= '0;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= ST_WR;
                        r_idx     <= r_idx + c_idx_one;
                        r_addr    <= r_addr + c_stride;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done           = r_done;
    assign pass           = r_done & (r_err_count == 8'd0) & ~r_timeout;
    assign timeout        = r_timeout;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_addr;
    assign first_err_data = r_first_data;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = w_pattern;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regtest_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regtest_master
// Purpose  : Self-checking bench: RAM-like AXI4-Lite slave with fault knobs
//            and a behavioural model of the expected run results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regtest_master;
    import axi_lite_regtest_pkg::*;

    localparam int NREGS = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic        busy, done, pass, timeout;
    logic [7:0]  err_count;
    logic [31:0] first_err_addr, first_err_data;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_regtest_master #(.C_NUM_REGS(NREGS)) dut (
        .ACLK(clk), .ARESET(rst), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- slave model with fault knobs ----------------
    logic        cfg_awready, cfg_wready, cfg_slverr_en;
    logic [31:0] cfg_stuck_mask, cfg_slverr_addr;
    logic [31:0] mem [0:255];
    logic        aw_got, w_got, s_bvalid, s_rvalid;
    logic [31:0] aw_a, w_d, s_rdata;
    logic [1:0]  s_bresp;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic        s_aw_hs, s_w_hs, s_have_aw, s_have_w;
    logic [31:0] s_addr, s_data;

    assign M_AXI_AWREADY = cfg_awready;
    assign M_AXI_WREADY  = cfg_wready;
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_BVALID  = s_bvalid;
    assign M_AXI_BRESP   = s_bresp;
    assign M_AXI_RVALID  = s_rvalid;
    assign M_AXI_RDATA   = s_rdata;
    assign M_AXI_RRESP   = 2'b00;
    assign s_aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
    assign s_w_hs    = M_AXI_WVALID & M_AXI_WREADY;
    assign s_have_aw = aw_got | s_aw_hs;
    assign s_have_w  = w_got | s_w_hs;
    assign s_addr    = aw_got ? aw_a : M_AXI_AWADDR;
    assign s_data    = w_got ? w_d : M_AXI_WDATA;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            s_bresp <= 2'b00; s_rdata <= '0; aw_a <= '0; w_d <= '0;
        end else begin
            if (s_bvalid && M_AXI_BREADY) s_bvalid <= 1'b0;
            if (s_rvalid && M_AXI_RREADY) s_rvalid <= 1'b0;
            if (s_have_aw && s_have_w && !s_bvalid) begin
                mem[s_addr[9:2]] <= s_data & ~cfg_stuck_mask;
                s_bvalid <= 1'b1;
                s_bresp  <= (cfg_slverr_en && s_addr == cfg_slverr_addr) ? 2'b10 : 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                wq_addr.push_back(s_addr);
                wq_data.push_back(s_data);
            end else begin
                if (s_aw_hs) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; end
                if (s_w_hs)  begin w_got  <= 1'b1; w_d  <= M_AXI_WDATA;  end
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                s_rvalid <= 1'b1;
                s_rdata  <= mem[M_AXI_ARADDR[9:2]];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS_32 : 32'h0);
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] m, input logic [31:0] s, input int idx);
        logic [31:0] v;
        case (m)
            2'd0: return s + 32'(idx);
            2'd1: return 32'h1 << (idx % 32);
            2'd2: begin
                v = (s == 32'h0) ? 32'hFFFF_FFFF : s;
                for (int k = 0; k < idx; k++) v = lfsr_step(v);
                return v;
            end
            default: return (idx % 2 == 1) ? ~s : s;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {55'h0, busy, done, pass, timeout, M_AXI_AWVALID,
             M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 64'h0);
        chk({tag, "_errcnt"}, {56'h0, err_count}, 64'h0);
        chk({tag, "_faddr"}, {32'h0, first_err_addr}, 64'h0);
        chk({tag, "_fdata"}, {32'h0, first_err_data}, 64'h0);
    endtask

    // Runs one test pass; mid_start>0 pulses start at that busy cycle,
    // edge_start pulses start so it lands on the DONE-entry edge.
    task automatic run_check(input string tag, input logic [1:0] m, input logic [31:0] s,
                             input int mid_start, input bit edge_start);
        logic [31:0] exp_w [NREGS];
        int          exp_err = 0;
        logic [31:0] exp_fa = 0, exp_fd = 0;
        logic [31:0] stored, a;
        int          cyc = 0;
        for (int i = 0; i < NREGS; i++) begin
            exp_w[i] = model_word(m, s, i);
            a = 32'(i * 4);
            stored = exp_w[i] & ~cfg_stuck_mask;
            if (cfg_slverr_en && a == cfg_slverr_addr) begin
                if (exp_err == 0) begin exp_fa = a; exp_fd = exp_w[i]; end
                exp_err++;
            end
            if (stored != exp_w[i]) begin
                if (exp_err == 0) begin exp_fa = a; exp_fd = stored; end
                exp_err++;
            end
        end
        if (exp_err > 255) exp_err = 255;
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        start = 1'b1; mode = m; seed = s;
        for (int t = 0; t < 5 * NREGS + 100; t++) begin
            @(negedge clk);
            start = 1'b0;
            mode  = 2'($urandom_range(0, 3));
            seed  = $urandom;
            if (busy) cyc++;
            if (done) break;
            if (mid_start > 0 && cyc == mid_start) start = 1'b1;
            if (edge_start && cyc == 5 * NREGS) start = 1'b1;
        end
        chk({tag, "_done"}, {63'h0, done}, 64'h1);
        chk({tag, "_cycles"}, 64'(cyc), 64'(5 * NREGS));
        chk({tag, "_pass"}, {63'h0, pass}, {63'h0, (exp_err == 0)});
        chk({tag, "_errcnt"}, {56'h0, err_count}, 64'(exp_err));
        chk({tag, "_faddr"}, {32'h0, first_err_addr}, {32'h0, exp_fa});
        chk({tag, "_fdata"}, {32'h0, first_err_data}, {32'h0, exp_fd});
        chk({tag, "_tmo"}, {63'h0, timeout}, 64'h0);
        chk({tag, "_nwr"}, 64'(wq_addr.size()), 64'(NREGS));
        for (int i = 0; i < NREGS && i < wq_addr.size(); i++) begin
            chk($sformatf("%s_wa%0d", tag, i), {32'h0, wq_addr[i]}, 64'(i * 4));
            chk($sformatf("%s_wd%0d", tag, i), {32'h0, wq_data[i]}, {32'h0, exp_w[i]});
        end
        repeat (3) @(negedge clk);
        chk({tag, "_hold"}, {62'h0, busy, done}, 64'h1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; mode = 2'd0; seed = 32'h0;
        cfg_awready = 1'b1; cfg_wready = 1'b1; cfg_slverr_en = 1'b0;
        cfg_stuck_mask = 32'h0; cfg_slverr_addr = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        chk("prot_strb", {55'h0, M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}, 64'h00F);
        rst = 1'b0;

        // incrementing pattern across the carry boundary
        run_check("incr", 2'd0, 32'h0101_FFFF, 0, 1'b0);
        chk("incr_w3", {32'h0, wq_data[3]}, 64'h0102_0002);

        // walking one wraps after bit 31
        run_check("walk", 2'd1, $urandom, 0, 1'b0);
        chk("walk_w33", {32'h0, wq_data[33]}, 64'h0000_0002);

        // checkerboard against a stuck-at-0 bit 4
        cfg_stuck_mask = 32'h0000_0010;
        run_check("stuck", 2'd3, 32'hDEAD_0011, 0, 1'b0);
        chk("stuck_fd", {32'h0, first_err_data}, 64'hDEAD_0001);
        cfg_stuck_mask = 32'h0;

        // single SLVERR on address 0x8
        cfg_slverr_en = 1'b1; cfg_slverr_addr = 32'h8;
        run_check("slverr", 2'd0, $urandom, 0, 1'b0);
        chk("slverr_fa", {32'h0, first_err_addr}, 64'h8);
        cfg_slverr_en = 1'b0;

        // randomized runs: zero LFSR seed, start while busy, start at DONE entry
        for (int r = 0; r < 4; r++) begin
            logic [1:0]  m;
            logic [31:0] s;
            m = (r == 1) ? 2'd2 : 2'($urandom_range(0, 3));
            s = (r == 1) ? 32'h0 : $urandom;
            run_check($sformatf("rnd%0d", r), m, s, (r == 2) ? 17 : 0, r == 3);
        end

        // AW never accepted: timeout abort
        cfg_awready = 1'b0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1; mode = 2'd0; seed = $urandom;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) cyc++;
            if (done) break;
        end
        chk("tmo_done", {63'h0, done}, 64'h1);
        chk("tmo_flag", {63'h0, timeout}, 64'h1);
        chk("tmo_errcnt", {56'h0, err_count}, 64'h1);
        chk("tmo_pass", {63'h0, pass}, 64'h0);
        chk("tmo_valids", {62'h0, M_AXI_AWVALID, M_AXI_WVALID}, 64'h0);
        chk("tmo_cycles", {63'h0, (cyc >= 1023 && cyc <= 1026)}, 64'h1);
        cfg_awready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset("tmo_rst");
        rst = 1'b0;

        // reset while a read is outstanding, then a clean rerun
        @(negedge clk);
        start = 1'b1; mode = 2'd2; seed = $urandom;
        cyc = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc > 30 && M_AXI_RREADY) break;
        end
        chk("midrst_rd", {63'h0, M_AXI_RREADY}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        rst = 1'b0;
        run_check("rerun", 2'd2, $urandom, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
